axi4lite_mem_ctrl: RTL and testbench

AXI4-Lite slave front-end that accepts AXI4-Lite read and write transactions and turns them into accesses on the single-port word memory (shared wr_en, 1-cycle registered read, write priority).
It sits between the AXI interconnect and the memory and acts as the memory's only initiator.
One transaction is in flight at a time, with round-robin arbitration between reads and writes.

---
 rtl/axi4lite_pkg.sv | 26 ++
 rtl/axi4lite_mem_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_axi4lite_mem_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite memory front-end: response codes,
// controller state encoding and the read/write arbitration token.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_EXEC = 3'd1,
    WR_RESP = 3'd2,
    RD_MEM  = 3'd3,
    RD_CAP  = 3'd4,
    RD_RESP = 3'd5
  } ctrl_state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } grant_t;

endpackage

// File: rtl/axi4lite_mem_ctrl.sv
// AXI4-Lite slave in front of a single-port word memory (registered read,
// write priority). One transaction in flight; reads and writes alternate
// on contention. Partial-strobe writes and out-of-range addresses are
// answered with an error response and never touch the memory.
module axi4lite_mem_ctrl
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 10
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wr_data,
  output logic                      mem_wr_en,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data
);

  // Any address bit above the word-address field selects nothing.
  function automatic logic addr_oor(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >> (ADDR_WIDTH + 2)) != '0;
  endfunction

  // Byte address to word index; the two byte-lane bits are dropped.
  function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [AXI_ADDR_WIDTH-1:0] a);
    return ADDR_WIDTH'(a >> 2);
  endfunction

  ctrl_state_t           state_q;
  grant_t                last_grant_q;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] aw_word_q;
  logic                  aw_oor_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wstrb_full_q;
  resp_t                 bresp_q, rresp_q;
  logic                  bvalid_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wr_data_q;
  logic                  mem_wr_en_q;

  logic                  in_idle, held, wr_req, wr_grant, rd_grant;
  logic                  aw_fire, w_fire, ar_fire, wr_done;
  logic                  cur_oor, cur_full;
  logic [ADDR_WIDTH-1:0] cur_word;
  logic [DATA_WIDTH-1:0] cur_wdata;

  // Arbitration: a half-accepted write owns the bus; on a fresh tie the
  // side that did not win last time goes first.
  always_comb begin
    held     = aw_held_q | w_held_q;
    wr_req   = AWVALID | WVALID;
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (held) begin
      wr_grant = 1'b1;
    end else if (ARVALID && wr_req) begin
      rd_grant = (last_grant_q == WRITE);
      wr_grant = (last_grant_q == READ);
    end else begin
      rd_grant = ARVALID;
      wr_grant = wr_req;
    end
  end

  assign in_idle = (state_q == IDLE);
  assign AWREADY = in_idle && !aw_held_q && wr_grant;
  assign WREADY  = in_idle && !w_held_q && wr_grant;
  assign ARREADY = in_idle && rd_grant;

  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;
  assign ar_fire = ARVALID && ARREADY;
  assign wr_done = in_idle && (aw_held_q || aw_fire) && (w_held_q || w_fire);

  // Write halves arriving this cycle bypass their holding registers.
  assign cur_oor   = aw_held_q ? aw_oor_q     : addr_oor(AWADDR);
  assign cur_word  = aw_held_q ? aw_word_q    : word_of(AWADDR);
  assign cur_full  = w_held_q  ? wstrb_full_q : (&WSTRB);
  assign cur_wdata = w_held_q  ? wdata_q      : WDATA;

  // Controller FSM with all AXI response and memory outputs registered.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= IDLE;
      last_grant_q  <= WRITE;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      aw_word_q     <= '0;
      aw_oor_q      <= 1'b0;
      wdata_q       <= '0;
      wstrb_full_q  <= 1'b0;
      bresp_q       <= OKAY;
      rresp_q       <= OKAY;
      bvalid_q      <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_wr_en_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (aw_fire) begin
            aw_held_q <= 1'b1;
            aw_word_q <= word_of(AWADDR);
            aw_oor_q  <= addr_oor(AWADDR);
          end
          if (w_fire) begin
            w_held_q     <= 1'b1;
            wdata_q      <= WDATA;
            wstrb_full_q <= &WSTRB;
          end
          if (wr_done) begin
            if (cur_oor) begin
              bresp_q  <= DECERR;
              bvalid_q <= 1'b1;
              state_q  <= WR_RESP;
            end else if (!cur_full) begin
              bresp_q  <= SLVERR;
              bvalid_q <= 1'b1;
              state_q  <= WR_RESP;
            end else begin
              mem_addr_q    <= cur_word;
              mem_wr_data_q <= cur_wdata;
              mem_wr_en_q   <= 1'b1;
              state_q       <= WR_EXEC;
            end
          end else if (ar_fire) begin
            if (addr_oor(ARADDR)) begin
              rdata_q  <= '0;
              rresp_q  <= DECERR;
              rvalid_q <= 1'b1;
              state_q  <= RD_RESP;
            end else begin
              mem_addr_q <= word_of(ARADDR);
              state_q    <= RD_MEM;
            end
          end
        end
        WR_EXEC: begin
          mem_wr_en_q <= 1'b0;
          bresp_q     <= OKAY;
          bvalid_q    <= 1'b1;
          state_q     <= WR_RESP;
        end
        WR_RESP: begin
          if (BREADY) begin
            bvalid_q     <= 1'b0;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            last_grant_q <= WRITE;
            state_q      <= IDLE;
          end
        end
        RD_MEM: begin
          state_q <= RD_CAP;
        end
        RD_CAP: begin
          rdata_q  <= mem_rd_data;
          rresp_q  <= OKAY;
          rvalid_q <= 1'b1;
          state_q  <= RD_RESP;
        end
        RD_RESP: begin
          if (RREADY) begin
            rvalid_q     <= 1'b0;
            last_grant_q <= READ;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BRESP       = bresp_q;
  assign BVALID      = bvalid_q;
  assign RRESP       = rresp_q;
  assign RVALID      = rvalid_q;
  assign RDATA       = rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_en   = mem_wr_en_q;

endmodule

// File: tb/tb_axi4lite_mem_ctrl.sv
// Directed plus randomized bench for axi4lite_mem_ctrl with a behavioural
// memory attached and a word-array reference model of the expected contents.
module tb_axi4lite_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [9:0]  AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b1;
  logic [9:0]  ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY = 1'b1;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_en;
  logic [31:0] mem_rd_data = '0;

  logic [31:0] mem_arr [64] = '{default: 32'h0};
  logic [31:0] ref_mem [64];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  axi4lite_mem_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .AXI_ADDR_WIDTH(10)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_rd_data(mem_rd_data)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Single-port memory: write has priority, read data registered.
  always @(posedge CLK) begin
    if (mem_wr_en) mem_arr[mem_addr] <= mem_wr_data;
    else           mem_rd_data <= mem_arr[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_bresp(input logic [9:0] a, input logic [3:0] s);
    if (a >= 10'h100) return 2'b11;
    if (s != 4'hF)    return 2'b10;
    return 2'b00;
  endfunction

  function automatic int model_word(input logic [9:0] a);
    return (int'(a) / 4) % 64;
  endfunction

  task automatic start_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output int acc);
    bit aw_ok, w_ok;
    aw_ok = 0; w_ok = 0; acc = -1;
    for (int t = 0; t < 40 && !(aw_ok && w_ok); t++) begin
      @(negedge CLK);
      AWADDR = a; WDATA = d; WSTRB = s;
      AWVALID = !aw_ok && (t >= aw_dly);
      WVALID  = !w_ok && (t >= w_dly);
      #1;
      if (t == 0) begin
        chk("idle_bvalid", 64'(BVALID), 64'd0);
        chk("idle_rvalid", 64'(RVALID), 64'd0);
      end
      chk("acc_no_wr", 64'(mem_wr_en), 64'd0);
      if (AWVALID && AWREADY) aw_ok = 1;
      if (WVALID && WREADY) w_ok = 1;
      if (aw_ok && w_ok) acc = cyc;
    end
    chk("wr_accept", 64'(aw_ok && w_ok), 64'd1);
  endtask

  task automatic finish_write(input int acc, input logic [9:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int b_hold);
    logic [1:0]  er;
    int          pulses, p_cyc, b_cyc;
    logic [5:0]  p_addr;
    logic [31:0] p_data;
    er = model_bresp(a, s);
    pulses = 0; p_cyc = -1; b_cyc = -1; p_addr = '0; p_data = '0;
    BREADY = (b_hold == 0);
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK);
      AWVALID = 0; WVALID = 0;
      #1;
      chk("wr_busy_rdy", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
      if (mem_wr_en) begin
        pulses++; p_cyc = cyc; p_addr = mem_addr; p_data = mem_wr_data;
      end
      if (BVALID) begin
        b_cyc = cyc;
        break;
      end
    end
    chk("wr_pulses", 64'(pulses), 64'((er == 2'b00) ? 1 : 0));
    chk("b_latency", 64'(b_cyc - acc), 64'((er == 2'b00) ? 2 : 1));
    chk("bresp", 64'(BRESP), 64'(er));
    if (er == 2'b00) begin
      chk("wr_pulse_cyc", 64'(p_cyc - acc), 64'd1);
      chk("wr_addr", 64'(p_addr), 64'(model_word(a)));
      chk("wr_data", 64'(p_data), 64'(d));
      ref_mem[model_word(a)] = d;
    end
    for (int h = 1; h <= b_hold; h++) begin
      @(negedge CLK);
      if (h == b_hold) BREADY = 1;
      #1;
      chk("b_hold_vld", 64'(BVALID), 64'd1);
      chk("b_hold_resp", 64'(BRESP), 64'(er));
    end
  endtask

  task automatic start_read(input logic [9:0] a, output int acc);
    bit ok;
    ok = 0; acc = -1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge CLK);
      ARADDR = a; ARVALID = 1;
      #1;
      if (t == 0) begin
        chk("idle_bvalid", 64'(BVALID), 64'd0);
        chk("idle_rvalid", 64'(RVALID), 64'd0);
      end
      if (ARREADY) begin
        ok = 1; acc = cyc;
      end
    end
    chk("rd_accept", 64'(ok), 64'd1);
  endtask

  task automatic finish_read(input int acc, input logic [9:0] a, input int r_hold);
    bit          oor;
    logic [31:0] ed;
    logic [1:0]  er;
    int          r_cyc;
    oor = (a >= 10'h100);
    ed  = oor ? 32'h0 : ref_mem[model_word(a)];
    er  = oor ? 2'b11 : 2'b00;
    r_cyc = -1;
    RREADY = (r_hold == 0);
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK);
      ARVALID = 0;
      #1;
      if (RVALID) begin
        r_cyc = cyc;
        break;
      end
      chk("rd_busy_rdy", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
      chk("rd_no_wr", 64'(mem_wr_en), 64'd0);
      if (cyc == acc + 1 && !oor) chk("rd_mem_addr", 64'(mem_addr), 64'(model_word(a)));
    end
    chk("r_latency", 64'(r_cyc - acc), 64'(oor ? 1 : 3));
    chk("rdata", 64'(RDATA), 64'(ed));
    chk("rresp", 64'(RRESP), 64'(er));
    for (int h = 1; h <= r_hold; h++) begin
      @(negedge CLK);
      if (h == r_hold) RREADY = 1;
      #1;
      chk("r_hold_vld", 64'(RVALID), 64'd1);
      chk("r_hold_data", 64'(RDATA), 64'(ed));
      chk("r_hold_resp", 64'(RRESP), 64'(er));
    end
  endtask

  initial begin
    int          acc, acc2, mark;
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  s;

    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

    // Reset values
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_bvalid", 64'(BVALID), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_bresp", 64'(BRESP), 64'd0);
    chk("rst_rresp", 64'(RRESP), 64'd0);
    chk("rst_rdata", 64'(RDATA), 64'd0);
    chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
    @(negedge CLK);
    RSTn = 1;

    // Basic write then read back
    start_write(10'h010, 32'hDEADBEEF, 4'hF, 0, 0, acc);
    finish_write(acc, 10'h010, 32'hDEADBEEF, 4'hF, 0);
    start_read(10'h010, acc);
    finish_read(acc, 10'h010, 0);

    // W three cycles ahead of AW, with a read waiting meanwhile
    @(negedge CLK);
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1; #1;
    chk("wfirst_wready", 64'(WREADY), 64'd1);
    @(negedge CLK);
    WVALID = 0; ARADDR = 10'h0FC; ARVALID = 1; #1;
    chk("wfirst_ar_blk1", 64'(ARREADY), 64'd0);
    @(negedge CLK); #1;
    chk("wfirst_ar_blk2", 64'(ARREADY), 64'd0);
    @(negedge CLK);
    AWADDR = 10'h0FC; AWVALID = 1; #1;
    chk("wfirst_ar_blk3", 64'(ARREADY), 64'd0);
    chk("wfirst_awready", 64'(AWREADY), 64'd1);
    acc = cyc;
    finish_write(acc, 10'h0FC, 32'hCAFEF00D, 4'hF, 0);
    start_read(10'h0FC, acc);
    finish_read(acc, 10'h0FC, 0);

    // Error responses
    start_write(10'h100, 32'h11111111, 4'hF, 0, 0, acc);
    finish_write(acc, 10'h100, 32'h11111111, 4'hF, 0);
    start_write(10'h020, 32'h22222222, 4'h3, 1, 0, acc);
    finish_write(acc, 10'h020, 32'h22222222, 4'h3, 1);
    start_read(10'h020, acc);
    finish_read(acc, 10'h020, 0);
    start_read(10'h200, acc);
    finish_read(acc, 10'h200, 0);

    // Back-pressure on R
    start_read(10'h010, acc);
    finish_read(acc, 10'h010, 5);

    // Reset pulse while the read response is waiting
    start_read(10'h010, acc);
    RREADY = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge CLK);
      ARVALID = 0; #1;
      if (RVALID) break;
    end
    chk("pre_rst_rvalid", 64'(RVALID), 64'd1);
    #2 RSTn = 0;
    #1;
    chk("mid_rst_rvalid", 64'(RVALID), 64'd0);
    chk("mid_rst_rdata", 64'(RDATA), 64'd0);
    chk("mid_rst_wr_en", 64'(mem_wr_en), 64'd0);
    @(negedge CLK);
    RSTn = 1; RREADY = 1;

    // Tie from reset: read first, then the waiting write
    @(negedge CLK);
    ARADDR = 10'h0FC; ARVALID = 1;
    AWADDR = 10'h040; WDATA = 32'h0BADF00D; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    #1;
    chk("tie1_arready", 64'(ARREADY), 64'd1);
    chk("tie1_wr_rdy", 64'({AWREADY, WREADY}), 64'd0);
    acc = cyc;
    finish_read(acc, 10'h0FC, 0);
    mark = cyc;
    start_write(10'h040, 32'h0BADF00D, 4'hF, 0, 0, acc2);
    chk("tie1_wr_next", 64'(acc2 - mark), 64'd1);
    finish_write(acc2, 10'h040, 32'h0BADF00D, 4'hF, 0);

    // After a read completes, the next tie goes to the write
    start_read(10'h040, acc);
    finish_read(acc, 10'h040, 0);
    @(negedge CLK);
    ARADDR = 10'h040; ARVALID = 1;
    AWADDR = 10'h044; WDATA = 32'h5A5A1234; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    #1;
    chk("tie2_wr_rdy", 64'({AWREADY, WREADY}), 64'd3);
    chk("tie2_arready", 64'(ARREADY), 64'd0);
    acc = cyc;
    finish_write(acc, 10'h044, 32'h5A5A1234, 4'hF, 0);
    mark = cyc;
    start_read(10'h040, acc2);
    chk("tie2_rd_next", 64'(acc2 - mark), 64'd1);
    finish_read(acc2, 10'h040, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      a = 10'($urandom_range(255, 0));
      if ($urandom_range(7, 0) == 0) a = 10'($urandom_range(1023, 256));
      if ($urandom_range(1, 0) == 1) begin
        d = $urandom;
        s = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'hF;
        start_write(a, d, s, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), acc);
        finish_write(acc, a, d, s, int'($urandom_range(2, 0)));
      end else begin
        start_read(a, acc);
        finish_read(acc, a, int'($urandom_range(3, 0)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
